// File: rtl/lib_voq_requester.sv
// ============================================================================
// Module   : lib_voq_requester
// Purpose  : Requester side of an NxM separable allocator. Incoming flits are
//            sorted into M virtual output queues; non-empty queues raise a
//            request bit and a valid one-hot grant pops the granted head.
// Options  : LIB_VOQ_REQUESTER_ERROR_EN adds a sticky o_error flag for
//            malformed grants (multi-hot, or granted queue empty).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lib_voq_requester #(
    parameter int M     = 4,
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     i_data,
    input  logic [$clog2(M)-1:0] i_dest,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [0:M-1]         o_request,
    input  logic [0:M-1]         i_grant,
    output logic [WIDTH-1:0]     o_data,
    output logic                 o_valid,
    output logic [$clog2(M)-1:0] o_dest
`ifdef LIB_VOQ_REQUESTER_ERROR_EN
    ,
    output logic                 o_error
`endif
);

    localparam int c_dw = $clog2(M);
    localparam int c_pw = $clog2(DEPTH);
    localparam int c_cw = c_pw + 1;
    localparam logic [c_cw-1:0] c_full    = c_cw'(DEPTH);
    localparam logic [c_pw-1:0] c_ptr_one = c_pw'(1);
    localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);

    logic [WIDTH-1:0] r_mem   [M][DEPTH];
    logic [c_pw-1:0]  r_wptr  [M];
    logic [c_pw-1:0]  r_rptr  [M];
    logic [c_cw-1:0]  r_count [M];

    logic             w_push;
    logic             w_onehot;
    logic             w_valid_grant;
    logic [c_dw-1:0]  w_gidx;
    logic [M-1:0]     w_push_vec;
    logic [M-1:0]     w_pop_vec;

    // Request row: one bit per non-empty queue, from registered counts only.
    always_comb begin
        for (int m = 0; m < M; m++) begin
            o_request[m] = (r_count[m] != '0);
        end
    end

    // Grant decode: locate the set bit and accept only a one-hot grant on a non-empty queue.
    always_comb begin
        w_gidx = '0;
        for (int m = 0; m < M; m++) begin
            if (i_grant[m]) begin
                w_gidx = c_dw'(m);
            end
        end
        w_onehot      = ($countones(i_grant) == 1);
        w_valid_grant = w_onehot && o_request[w_gidx];
    end

    // Push acceptance depends only on the registered count, never on the grant.
    always_comb begin
        o_ready = 1'b0;
        if (int'(i_dest) < M) begin
            o_ready = (r_count[i_dest] != c_full);
        end
        w_push = i_valid && o_ready;
    end

    // Per-queue push/pop strobes.
    always_comb begin
        for (int m = 0; m < M; m++) begin
            w_push_vec[m] = w_push && (i_dest == c_dw'(m));
            w_pop_vec[m]  = w_valid_grant && (w_gidx == c_dw'(m));
        end
    end

    // Output presentation: head of the granted queue, forced to zero when idle.
    always_comb begin
        o_valid = w_valid_grant;
        o_dest  = w_valid_grant ? w_gidx : '0;
        o_data  = w_valid_grant ? r_mem[w_gidx][r_rptr[w_gidx]] : '0;
    end

    // Pointer and occupancy bookkeeping for every queue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int m = 0; m < M; m++) begin
                r_wptr[m]  <= '0;
                r_rptr[m]  <= '0;
                r_count[m] <= '0;
            end
        end else begin
            for (int m = 0; m < M; m++) begin
                if (w_push_vec[m]) begin
                    r_wptr[m] <= r_wptr[m] + c_ptr_one;
                end
                if (w_pop_vec[m]) begin
                    r_rptr[m] <= r_rptr[m] + c_ptr_one;
                end
                case ({w_push_vec[m], w_pop_vec[m]})
                    2'b10:   r_count[m] <= r_count[m] + c_cnt_one;
                    2'b01:   r_count[m] <= r_count[m] - c_cnt_one;
                    default: r_count[m] <= r_count[m];
                endcase
            end
        end
    end

    // Flit storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        for (int m = 0; m < M; m++) begin
            if (w_push_vec[m]) begin
                r_mem[m][r_wptr[m]] <= i_data;
            end
        end
    end

`ifdef LIB_VOQ_REQUESTER_ERROR_EN
    logic w_bad_grant;
    logic r_error;

    assign w_bad_grant = ($countones(i_grant) > 1) || (w_onehot && !o_request[w_gidx]);
    assign o_error     = r_error;

    // Sticky flag for malformed grants; only reset clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_error <= 1'b0;
        end else if (w_bad_grant) begin
            r_error <= 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_lib_voq_requester.sv
`default_nettype none

module tb_lib_voq_requester;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] data_i;
    logic [1:0]  dest_i;
    logic        valid_i;
    logic        ready_o;
    logic [0:3]  request_o;
    logic [0:3]  grant;
    logic [31:0] data_o;
    logic        valid_o;
    logic [1:0]  dest_o;
`ifdef LIB_VOQ_REQUESTER_ERROR_EN
    logic        err_o;
`endif

    int tests_run = 0;
    int fails     = 0;

    // Scoreboard: expected flits per VOQ, pushed on accepted stimulus, popped on grant.
    logic [31:0] sb [4][$];

    lib_voq_requester #(.M(4), .DEPTH(4), .WIDTH(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_data   (data_i),
        .i_dest   (dest_i),
        .i_valid  (valid_i),
        .o_ready  (ready_o),
        .o_request(request_o),
        .i_grant  (grant),
        .o_data   (data_o),
        .o_valid  (valid_o),
        .o_dest   (dest_o)
`ifdef LIB_VOQ_REQUESTER_ERROR_EN
        ,
        .o_error  (err_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [0:3] exp_req();
        logic [0:3] r;
        for (int m = 0; m < 4; m++) r[m] = (sb[m].size() != 0);
        return r;
    endfunction

    // Drive one cycle of stimulus just after the edge, return at the falling edge.
    task automatic cyc(input logic v, input logic [31:0] d, input logic [1:0] ds, input logic [0:3] g);
        @(posedge clk);
        #1;
        valid_i = v;
        data_i  = d;
        dest_i  = ds;
        grant   = g;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        valid_i = 1'b0; data_i = '0; dest_i = '0; grant = '0;
        #3;
        tests_run++; if (request_o !== 4'b0000) begin fails++; $display("FAIL reset_request got=%b exp=0000", request_o); end
        tests_run++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        tests_run++; if (ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
        tests_run++; if (data_o !== 32'h0 || dest_o !== 2'd0) begin fails++; $display("FAIL reset_data got=%h/%0d exp=0/0", data_o, dest_o); end
`ifdef LIB_VOQ_REQUESTER_ERROR_EN
        tests_run++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_error got=%b exp=0", err_o); end
`endif
        #9;
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        logic [31:0] e;
        cyc(1'b1, 32'hA1, 2'd2, 4'b0000);
        tests_run++; if (ready_o !== 1'b1) begin fails++; $display("FAIL single_ready got=%b exp=1", ready_o); end
        tests_run++; if (request_o !== 4'b0000) begin fails++; $display("FAIL single_nobypass got=%b exp=0000", request_o); end
        sb[2].push_back(32'hA1);
        cyc(1'b0, 32'h0, 2'd0, 4'b0000);
        tests_run++; if (request_o !== 4'b0010) begin fails++; $display("FAIL single_request got=%b exp=0010", request_o); end
        cyc(1'b0, 32'h0, 2'd0, 4'b0010);
        e = sb[2].pop_front();
        tests_run++; if (valid_o !== 1'b1) begin fails++; $display("FAIL single_valid got=%b exp=1", valid_o); end
        tests_run++; if (data_o !== e) begin fails++; $display("FAIL single_data got=%h exp=%h", data_o, e); end
        tests_run++; if (dest_o !== 2'd2) begin fails++; $display("FAIL single_dest got=%0d exp=2", dest_o); end
        cyc(1'b0, 32'h0, 2'd0, 4'b0000);
        tests_run++; if (request_o !== exp_req()) begin fails++; $display("FAIL single_drained got=%b exp=%b", request_o, exp_req()); end
    endtask

    task automatic test_fill_order();
        logic [31:0] e;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'h10 + 32'(i), 2'd1, 4'b0000);
            tests_run++; if (ready_o !== 1'b1) begin fails++; $display("FAIL fill_ready%0d got=%b exp=1", i, ready_o); end
            sb[1].push_back(32'h10 + 32'(i));
        end
        cyc(1'b1, 32'h99, 2'd1, 4'b0000);
        tests_run++; if (ready_o !== 1'b0) begin fails++; $display("FAIL fill_full_ready got=%b exp=0", ready_o); end
        cyc(1'b0, 32'h0, 2'd0, 4'b0000);
        tests_run++; if (ready_o !== 1'b1) begin fails++; $display("FAIL fill_other_ready got=%b exp=1", ready_o); end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 32'h0, 2'd0, 4'b0100);
            e = sb[1].pop_front();
            tests_run++; if (valid_o !== 1'b1 || data_o !== e) begin fails++; $display("FAIL fill_pop%0d got=%b/%h exp=1/%h", i, valid_o, data_o, e); end
        end
        cyc(1'b0, 32'h0, 2'd0, 4'b0000);
        tests_run++; if (request_o !== exp_req()) begin fails++; $display("FAIL fill_drained got=%b exp=%b", request_o, exp_req()); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] e;
        cyc(1'b1, 32'h55, 2'd3, 4'b0000);
        sb[3].push_back(32'h55);
        cyc(1'b1, 32'h66, 2'd3, 4'b0001);
        e = sb[3].pop_front();
        tests_run++; if (ready_o !== 1'b1) begin fails++; $display("FAIL same_ready got=%b exp=1", ready_o); end
        tests_run++; if (valid_o !== 1'b1 || data_o !== e) begin fails++; $display("FAIL same_pop got=%b/%h exp=1/%h", valid_o, data_o, e); end
        sb[3].push_back(32'h66);
        cyc(1'b0, 32'h0, 2'd0, 4'b0001);
        e = sb[3].pop_front();
        tests_run++; if (data_o !== e || dest_o !== 2'd3) begin fails++; $display("FAIL same_newhead got=%h/%0d exp=%h/3", data_o, dest_o, e); end
        // Full queue refuses a push even while it is being popped.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'h80 + 32'(i), 2'd3, 4'b0000);
            sb[3].push_back(32'h80 + 32'(i));
        end
        cyc(1'b1, 32'h90, 2'd3, 4'b0001);
        e = sb[3].pop_front();
        tests_run++; if (ready_o !== 1'b0) begin fails++; $display("FAIL same_full_ready got=%b exp=0", ready_o); end
        tests_run++; if (data_o !== e) begin fails++; $display("FAIL same_full_pop got=%h exp=%h", data_o, e); end
        // Push to VOQ 0 while popping VOQ 3.
        cyc(1'b1, 32'hB0, 2'd0, 4'b0001);
        e = sb[3].pop_front();
        sb[0].push_back(32'hB0);
        tests_run++; if (data_o !== e) begin fails++; $display("FAIL indep_pop got=%h exp=%h", data_o, e); end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 32'h0, 2'd0, 4'b0001);
            e = sb[3].pop_front();
            tests_run++; if (data_o !== e) begin fails++; $display("FAIL same_drain%0d got=%h exp=%h", i, data_o, e); end
        end
        cyc(1'b0, 32'h0, 2'd0, 4'b1000);
        e = sb[0].pop_front();
        tests_run++; if (valid_o !== 1'b1 || data_o !== e || dest_o !== 2'd0) begin fails++; $display("FAIL indep_push got=%b/%h/%0d exp=1/%h/0", valid_o, data_o, dest_o, e); end
    endtask

    task automatic test_multi_grant();
        logic [31:0] e;
        cyc(1'b1, 32'h21, 2'd1, 4'b0000); sb[1].push_back(32'h21);
        cyc(1'b1, 32'h22, 2'd2, 4'b0000); sb[2].push_back(32'h22);
        cyc(1'b0, 32'h0, 2'd0, 4'b0110);
        tests_run++; if (valid_o !== 1'b0 || data_o !== 32'h0 || dest_o !== 2'd0) begin fails++; $display("FAIL multi_ignored got=%b/%h/%0d exp=0/0/0", valid_o, data_o, dest_o); end
        cyc(1'b0, 32'h0, 2'd0, 4'b0000);
        tests_run++; if (request_o !== exp_req()) begin fails++; $display("FAIL multi_kept got=%b exp=%b", request_o, exp_req()); end
`ifdef LIB_VOQ_REQUESTER_ERROR_EN
        tests_run++; if (err_o !== 1'b1) begin fails++; $display("FAIL multi_error got=%b exp=1", err_o); end
`endif
        cyc(1'b0, 32'h0, 2'd0, 4'b0100);
        e = sb[1].pop_front();
        tests_run++; if (data_o !== e) begin fails++; $display("FAIL multi_pop1 got=%h exp=%h", data_o, e); end
        cyc(1'b0, 32'h0, 2'd0, 4'b0010);
        e = sb[2].pop_front();
        tests_run++; if (data_o !== e) begin fails++; $display("FAIL multi_pop2 got=%h exp=%h", data_o, e); end
    endtask

    task automatic test_empty_grant();
        logic [31:0] e;
        cyc(1'b0, 32'h0, 2'd0, 4'b1000);
        tests_run++; if (valid_o !== 1'b0) begin fails++; $display("FAIL empty_valid got=%b exp=0", valid_o); end
        cyc(1'b1, 32'h77, 2'd0, 4'b0000); sb[0].push_back(32'h77);
        cyc(1'b0, 32'h0, 2'd0, 4'b0000);
        tests_run++; if (request_o !== exp_req()) begin fails++; $display("FAIL empty_after got=%b exp=%b", request_o, exp_req()); end
        cyc(1'b0, 32'h0, 2'd0, 4'b1000);
        e = sb[0].pop_front();
        tests_run++; if (valid_o !== 1'b1 || data_o !== e) begin fails++; $display("FAIL empty_ptr got=%b/%h exp=1/%h", valid_o, data_o, e); end
        cyc(1'b0, 32'h0, 2'd0, 4'b0000);
        tests_run++; if (request_o !== exp_req()) begin fails++; $display("FAIL empty_drained got=%b exp=%b", request_o, exp_req()); end
`ifdef LIB_VOQ_REQUESTER_ERROR_EN
        tests_run++; if (err_o !== 1'b1) begin fails++; $display("FAIL empty_error got=%b exp=1", err_o); end
`endif
    endtask

    task automatic test_mid_reset();
        logic [31:0] e;
        cyc(1'b1, 32'hC0, 2'd0, 4'b0000); sb[0].push_back(32'hC0);
        cyc(1'b1, 32'hC1, 2'd0, 4'b0000); sb[0].push_back(32'hC1);
        cyc(1'b1, 32'hD0, 2'd2, 4'b0000); sb[2].push_back(32'hD0);
        cyc(1'b0, 32'h0, 2'd0, 4'b1000);
        e = sb[0].pop_front();
        tests_run++; if (valid_o !== 1'b1 || data_o !== e) begin fails++; $display("FAIL mid_pop got=%b/%h exp=1/%h", valid_o, data_o, e); end
        #2;
        reset_n = 1'b0;
        #1;
        for (int m = 0; m < 4; m++) sb[m].delete();
        tests_run++; if (request_o !== exp_req()) begin fails++; $display("FAIL mid_request got=%b exp=%b", request_o, exp_req()); end
        tests_run++; if (valid_o !== 1'b0 || data_o !== 32'h0) begin fails++; $display("FAIL mid_valid got=%b/%h exp=0/0", valid_o, data_o); end
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        cyc(1'b0, 32'h0, 2'd0, 4'b0000);
        tests_run++; if (ready_o !== 1'b1 || request_o !== 4'b0000) begin fails++; $display("FAIL mid_release got=%b/%b exp=1/0000", ready_o, request_o); end
`ifdef LIB_VOQ_REQUESTER_ERROR_EN
        tests_run++; if (err_o !== 1'b0) begin fails++; $display("FAIL mid_error_clear got=%b exp=0", err_o); end
`endif
        cyc(1'b1, 32'hE5, 2'd2, 4'b0000); sb[2].push_back(32'hE5);
        tests_run++; if (ready_o !== 1'b1) begin fails++; $display("FAIL mid_ready2 got=%b exp=1", ready_o); end
        cyc(1'b0, 32'h0, 2'd0, 4'b0010);
        e = sb[2].pop_front();
        tests_run++; if (valid_o !== 1'b1 || data_o !== e) begin fails++; $display("FAIL mid_post got=%b/%h exp=1/%h", valid_o, data_o, e); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_order();
        test_same_cycle();
        test_multi_grant();
        test_empty_grant();
        test_mid_reset();
        cyc(1'b0, 32'h0, 2'd0, 4'b0000);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

`default_nettype wire
